riscv_retire_trace_tx: RTL and testbench

RISCV_RETIRE_TRACE_TX -- requirements
Module: riscv_retire_trace_tx

---
 rtl/riscv_retire_trace_tx.sv | 205 ++++++++++++++++++++
 tb/tb_riscv_retire_trace_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_retire_trace_tx.sv
`default_nettype none
// ============================================================================
// Module  : riscv_retire_trace_tx
// Brief   : Captures retiring MEM-stage instructions into a record FIFO and
//           streams each record out as four 32-bit beats (seq, instr, pc, result).
// Rev     : 1.0
// ============================================================================
module riscv_retire_trace_tx #(
   parameter int                     DATA_WIDTH  = 64,
   parameter int                     INSTR_WIDTH = 32,
   parameter int                     DEPTH       = 8,
   parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = INSTR_WIDTH'(32'h0010_0073)
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   i_enable,
   input  logic                   i_valid_instr,
   input  logic                   i_stall_mem,
   input  logic                   i_flush_mem,
   input  logic [DATA_WIDTH-1:0]  i_pc,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   input  logic [DATA_WIDTH-1:0]  i_result,
   output logic [31:0]            o_tdata,
   output logic                   o_tvalid,
   input  logic                   i_tready,
   output logic                   o_tlast,
   output logic                   o_overflow,
   output logic [15:0]            o_drop_count,
   output logic                   o_halted
);

   localparam int             c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_AW:0]  c_DEPTH_CNT = (c_AW + 1)'(DEPTH);
   localparam logic [c_AW:0]  c_CNT_ONE   = (c_AW + 1)'(1);
   localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

   localparam logic [1:0] c_ST_RUN       = 2'd0;
   localparam logic [1:0] c_ST_HALT_PEND = 2'd1;
   localparam logic [1:0] c_ST_HALTED    = 2'd2;

   // Record storage; payload needs no reset since occupancy is tracked by count_q.
   logic [15:0] seq_mem_q   [DEPTH];
   logic        halt_mem_q  [DEPTH];
   logic [31:0] instr_mem_q [DEPTH];
   logic [31:0] pc_mem_q    [DEPTH];
   logic [31:0] res_mem_q   [DEPTH];

   logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_AW:0]   count_q, count_d;
   logic [1:0]      beat_q, beat_d;
   logic [15:0]     seq_q, seq_d;
   logic            overflow_q, overflow_d;
   logic [15:0]     drop_count_q, drop_count_d;
   logic [1:0]      state_q, state_d;

   logic [31:0] w_instr32;
   logic        w_tvalid;
   logic        w_fire;
   logic        w_pop;
   logic        w_retire;
   logic        w_push;
   logic        w_drop;
   logic        w_halt_rec;
   logic        w_head_halt;

   generate
      if (INSTR_WIDTH >= 32) begin : g_instr_trunc
         assign w_instr32 = i_instr[31:0];
      end else begin : g_instr_zext
         assign w_instr32 = {{(32 - INSTR_WIDTH){1'b0}}, i_instr};
      end
   endgenerate

   generate
      if (DATA_WIDTH > 32) begin : g_unused_hi
         logic w_unused_hi;
         assign w_unused_hi = ^{i_pc[DATA_WIDTH-1:32], i_result[DATA_WIDTH-1:32]};
      end
   endgenerate

   assign w_tvalid    = (count_q != '0);
   assign w_fire      = w_tvalid & i_tready;
   assign w_pop       = w_fire & (beat_q == 2'd3);
   assign w_retire    = i_enable & i_valid_instr & ~i_stall_mem & ~i_flush_mem
                        & (state_q == c_ST_RUN);
   // A full FIFO still accepts when the head record leaves on the same edge.
   assign w_push      = w_retire & ((count_q != c_DEPTH_CNT) | w_pop);
   assign w_drop      = w_retire & ~w_push;
   assign w_halt_rec  = (i_instr == HALT_INSTR);
   assign w_head_halt = halt_mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      beat_d       = beat_q;
      seq_d        = seq_q;
      overflow_d   = overflow_q | w_drop;
      drop_count_d = drop_count_q;

      if (w_push) begin
         wr_ptr_d = wr_ptr_q + c_PTR_ONE;
         seq_d    = seq_q + 16'd1;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
         count_d = count_q + c_CNT_ONE;
      end else if (!w_push && w_pop) begin
         count_d = count_q - c_CNT_ONE;
      end
      if (w_fire) begin
         beat_d = beat_q + 2'd1;
      end
      if (w_drop && (drop_count_q != 16'hFFFF)) begin
         drop_count_d = drop_count_q + 16'd1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         beat_q       <= 2'd0;
         seq_q        <= 16'd0;
         overflow_q   <= 1'b0;
         drop_count_q <= 16'd0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         beat_q       <= beat_d;
         seq_q        <= seq_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (w_push) begin
         seq_mem_q[wr_ptr_q]   <= seq_q;
         halt_mem_q[wr_ptr_q]  <= w_halt_rec;
         instr_mem_q[wr_ptr_q] <= w_instr32;
         pc_mem_q[wr_ptr_q]    <= i_pc[31:0];
         res_mem_q[wr_ptr_q]   <= i_result[31:0];
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= c_ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Only one halt record can ever be in flight, so the head flag identifies it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_RUN: begin
            if (w_push && w_halt_rec) begin
               state_d = c_ST_HALT_PEND;
            end
         end
         c_ST_HALT_PEND: begin
            if (w_pop && w_head_halt) begin
               state_d = c_ST_HALTED;
            end
         end
         c_ST_HALTED: begin
            state_d = c_ST_HALTED;
         end
         default: begin
            state_d = c_ST_RUN;
         end
      endcase
   end

   always_comb begin
      o_halted = (state_q == c_ST_HALTED);
   end

   always_comb begin
      o_tdata = 32'd0;
      if (w_tvalid) begin
         case (beat_q)
            2'd0:    o_tdata = {seq_mem_q[rd_ptr_q], 15'd0, halt_mem_q[rd_ptr_q]};
            2'd1:    o_tdata = instr_mem_q[rd_ptr_q];
            2'd2:    o_tdata = pc_mem_q[rd_ptr_q];
            default: o_tdata = res_mem_q[rd_ptr_q];
         endcase
      end
   end

   assign o_tvalid     = w_tvalid;
   assign o_tlast      = w_tvalid & (beat_q == 2'd3);
   assign o_overflow   = overflow_q;
   assign o_drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_retire_trace_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_riscv_retire_trace_tx
// Brief   : Directed bench for riscv_retire_trace_tx with a record-queue model.
// Rev     : 1.0
// ============================================================================
module tb_riscv_retire_trace_tx;

   localparam int          DW    = 64;
   localparam int          IW    = 32;
   localparam int          DEPTH = 8;
   localparam logic [31:0] HALT  = 32'h0010_0073;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          i_enable = 1'b1;
   logic          i_valid_instr = 1'b0;
   logic          i_stall_mem = 1'b0;
   logic          i_flush_mem = 1'b0;
   logic [DW-1:0] i_pc = '0;
   logic [IW-1:0] i_instr = '0;
   logic [DW-1:0] i_result = '0;
   logic [31:0]   o_tdata;
   logic          o_tvalid;
   logic          i_tready = 1'b1;
   logic          o_tlast;
   logic          o_overflow;
   logic [15:0]   o_drop_count;
   logic          o_halted;

   always #5 aclk = ~aclk;

   riscv_retire_trace_tx #(
      .DATA_WIDTH(DW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .HALT_INSTR(HALT)
   ) dut (
      .aclk(aclk), .areset(areset), .i_enable(i_enable),
      .i_valid_instr(i_valid_instr), .i_stall_mem(i_stall_mem),
      .i_flush_mem(i_flush_mem), .i_pc(i_pc), .i_instr(i_instr),
      .i_result(i_result), .o_tdata(o_tdata), .o_tvalid(o_tvalid),
      .i_tready(i_tready), .o_tlast(o_tlast), .o_overflow(o_overflow),
      .o_drop_count(o_drop_count), .o_halted(o_halted)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   // Model: a queue of whole records plus the index of the beat on offer.
   typedef struct {
      logic [15:0] seq;
      logic        h;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] res;
   } rec_t;

   rec_t        mq[$];
   int          mbeat    = 0;
   logic [15:0] mseq     = '0;
   logic        mover    = 1'b0;
   logic [15:0] mdrop    = '0;
   logic        mpend    = 1'b0;
   logic        mhalted  = 1'b0;
   bit          mstarted = 1'b0;

   function automatic logic [31:0] exp_word(input rec_t r, input int b);
      case (b)
         0:       return {r.seq, 15'd0, r.h};
         1:       return r.instr;
         2:       return r.pc;
         default: return r.res;
      endcase
   endfunction

   always @(posedge aclk) begin : m_step
      bit   fire, pop, ret;
      rec_t r;
      if (areset) begin
         mq.delete();
         mbeat = 0; mseq = '0; mover = 1'b0; mdrop = '0;
         mpend = 1'b0; mhalted = 1'b0; mstarted = 1'b1;
      end else if (mstarted) begin
         ret  = i_enable && i_valid_instr && !i_stall_mem && !i_flush_mem && !mpend && !mhalted;
         fire = (mq.size() != 0) && i_tready;
         pop  = fire && (mbeat == 3);
         if (pop) begin
            if (mq[0].h) begin
               mhalted = 1'b1;
               mpend   = 1'b0;
            end
            void'(mq.pop_front());
         end
         if (fire) mbeat = (mbeat + 1) % 4;
         if (ret) begin
            if (mq.size() < DEPTH) begin
               r.seq   = mseq;
               r.h     = (i_instr == HALT);
               r.instr = i_instr;
               r.pc    = i_pc[31:0];
               r.res   = i_result[31:0];
               mq.push_back(r);
               mseq = mseq + 16'd1;
               if (r.h) mpend = 1'b1;
            end else begin
               mover = 1'b1;
               if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
            end
         end
      end
   end

   logic        hold_prev = 1'b0;
   logic [31:0] prev_data = '0;
   logic [31:0] log_q[$];

   always @(negedge aclk) begin
      if (mstarted) begin
         check("tvalid", o_tvalid, mq.size() != 0);
         if (mq.size() != 0) begin
            check("tdata", o_tdata, exp_word(mq[0], mbeat));
            check("tlast", o_tlast, mbeat == 3);
         end else begin
            check("tlast_idle", o_tlast, 1'b0);
         end
         check("overflow", o_overflow, mover);
         check("drop_count", o_drop_count, mdrop);
         check("halted", o_halted, mhalted);
         if (hold_prev) check("hold_stable", o_tdata, prev_data);
         hold_prev = o_tvalid && !i_tready && !areset;
         prev_data = o_tdata;
         if (!areset && o_tvalid && i_tready) log_q.push_back(o_tdata);
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic set_retire(input logic [63:0] pc, input logic [31:0] instr, input logic [63:0] res);
      i_enable      = 1'b1;
      i_valid_instr = 1'b1;
      i_pc          = pc;
      i_instr       = instr;
      i_result      = res;
   endtask

   task automatic clr_retire();
      i_valid_instr = 1'b0;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      ticks(2);
      areset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "timeout");
   end

   int          base;
   logic [31:0] ri;

   initial begin
      ticks(3);
      areset = 1'b0;
      check("rst_tvalid", o_tvalid, 1'b0);
      check("rst_tdata", o_tdata, 32'h0);
      check("rst_tlast", o_tlast, 1'b0);
      check("rst_overflow", o_overflow, 1'b0);
      check("rst_drop", o_drop_count, 16'h0);
      check("rst_halted", o_halted, 1'b0);

      // single record, beats on consecutive cycles after the retire edge
      set_retire(64'h100, 32'h0000_0013, 64'h5);
      tick();
      clr_retire();
      check("single_b0_valid", o_tvalid, 1'b1);
      check("single_b0", o_tdata, 32'h0000_0000);
      tick();
      check("single_b1", o_tdata, 32'h0000_0013);
      check("single_b1_last", o_tlast, 1'b0);
      tick();
      check("single_b2", o_tdata, 32'h0000_0100);
      tick();
      check("single_b3", o_tdata, 32'h0000_0005);
      check("single_b3_last", o_tlast, 1'b1);
      tick();
      check("single_done", o_tvalid, 1'b0);

      // qualified-off retires produce nothing
      base = log_q.size();
      set_retire(64'h200, 32'h13, 64'h1);
      i_stall_mem = 1'b1; tick();
      i_stall_mem = 1'b0; i_flush_mem = 1'b1; tick();
      i_flush_mem = 1'b0; i_enable = 1'b0; tick();
      clr_retire(); i_enable = 1'b1;
      ticks(3);
      check("gated_no_beats", log_q.size() - base, 0);
      set_retire(64'h204, 32'h13, 64'h2);
      tick();
      clr_retire();
      check("gated_seq_next", o_tdata, 32'h0001_0000);
      ticks(6);

      // overflow with sink stalled
      do_reset();
      i_tready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         set_retire(64'h2000 + 64'(k * 4), 32'h33 + 32'(k), 64'(k));
         tick();
      end
      clr_retire();
      tick();
      check("ovf_drop2", o_drop_count, 16'd2);
      check("ovf_flag", o_overflow, 1'b1);
      base = log_q.size();
      i_tready = 1'b1;
      ticks(40);
      check("ovf_beats", log_q.size() - base, 32);
      if (log_q.size() >= base + 32) begin
         for (int k = 0; k < 8; k++) check("ovf_seq_order", log_q[base + 4 * k], {k[15:0], 16'h0});
      end

      // halt record and subsequent retires
      do_reset();
      i_tready = 1'b1;
      base = log_q.size();
      set_retire(64'h400, 32'h13, 64'h1); tick();
      set_retire(64'h404, HALT, 64'h2); tick();
      set_retire(64'h408, 32'h13, 64'h3); ticks(3);
      clr_retire();
      ticks(12);
      check("halt_beats", log_q.size() - base, 8);
      if (log_q.size() >= base + 8) begin
         check("halt_b0", log_q[base + 4], 32'h0001_0001);
         check("halt_b3", log_q[base + 7], 32'h0000_0002);
      end
      check("halt_flag", o_halted, 1'b1);
      check("halt_drop", o_drop_count, 16'd0);
      set_retire(64'h40C, 32'h13, 64'h4); tick(); clr_retire();
      check("halt_ignore", o_tvalid, 1'b0);

      // reset during beat2
      do_reset();
      i_tready = 1'b1;
      set_retire(64'hDEAD_0600, 32'h13, 64'h7);
      tick();
      clr_retire();
      ticks(2);
      check("rstmid_beat2", o_tdata, 32'hDEAD_0600);
      areset = 1'b1;
      set_retire(64'h700, 32'h13, 64'h8);
      tick();
      check("rstmid_tvalid", o_tvalid, 1'b0);
      tick();
      clr_retire();
      areset = 1'b0;
      tick();
      check("rstmid_idle", o_tvalid, 1'b0);
      set_retire(64'h800, 32'h13, 64'h9);
      tick();
      clr_retire();
      check("rstmid_seq0", o_tdata, 32'h0000_0000);
      ticks(6);

      // throttled sink, model checks every cycle
      do_reset();
      for (int k = 0; k < 1000; k++) begin
         ri = $urandom;
         if (ri == HALT) ri = ri ^ 32'h1;
         set_retire({32'h0, $urandom}, ri, {32'h0, $urandom});
         i_tready = ($urandom_range(0, 9) < 8);
         tick();
         clr_retire();
         repeat ($urandom_range(2, 6)) begin
            i_tready = ($urandom_range(0, 9) < 8);
            tick();
         end
      end
      i_tready = 1'b1;
      ticks(50);
      check("rand_drained", o_tvalid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
